decode_regfile_v2: RTL and testbench
====================================

Name: decode_regfile_v2

Overview:
- Parametrised successor of the core's decode stage.
- Holds the architectural register file and splits the 32-bit instruction into its fields.
- Reads two source operands and registers the result into a decode/execute pipeline register.
- Adds over the previous generation: a valid/ready handshake, flush, same-cycle write-back bypass, an optional hard-wired zero register and correct src2 register reporting.
- Sits between fetch and execute.

Parameters:
- DATA_W, 32, width of register and operand data.
- NREGS, 32, number of registers; power of two, 2 to 32. AW = clog2(NREGS).
- ZERO_REG, 0, when 1 register 0 reads 0 and ignores writes.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  instruction valid from fetch
- in_ready  out  1  decode can accept an instruction this cycle
- instruction  in  32  fields: [31:25] opcode, [24:20] dst, [19:15] src1, [14:10] src2, [9:0] offsetlo
- flush  in  1  discard the pipeline register contents
- WB  in  1  write-back enable
- WB_add  in  AW  write-back register index
- datain  in  DATA_W  write-back data
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- opcode  out  7  registered instruction[31:25]
- dst  out  5  registered instruction[24:20]
- src1_reg  out  5  registered instruction[19:15]
- src2_reg  out  5  registered instruction[14:10]
- src1  out  DATA_W  operand read at src1_reg (low AW bits index the file)
- src2  out  DATA_W  operand read at src2_reg
- offsetlo  out  10  registered instruction[9:0]

Behaviour:
- Reset (async, while rst=1):
  - All registers are cleared to 0.
  - out_valid=0, and opcode/dst/src*_reg/src1/src2/offsetlo are 0.
  - in_ready follows its combinational definition.
- Write-back:
  - When WB=1 on a clock edge, regfile[WB_add] <= datain.
  - The write is independent of the handshake and of flush.
  - With ZERO_REG=1 a write to index 0 is dropped.
- in_ready = !out_valid || out_ready (combinational; single-entry skid-less pipeline register).
- Accept: on an edge with in_valid && in_ready, all output fields and operands load and out_valid <= 1.
  - Decode latency is 1 cycle.
- Drain: if out_valid && out_ready and no new accept, out_valid <= 0.
- Hold: while out_valid=1 and out_ready=0, every output stays stable, including src1/src2.
  - Later write-backs to the held source registers do NOT update the held operands. Execute handles that hazard.
- Bypass: on an accept edge with WB=1 and WB_add equal to the source index, the operand loads datain instead of the stale file value.
  - Applies to each port independently; both ports may bypass.
  - With ZERO_REG=1 and source index 0 the operand is always 0, bypass included.
- Index width: source and WB_add indices use their low AW bits. Upper bits are ignored for indexing but reported unchanged in src*_reg.
- Flush: on an edge with flush=1, out_valid <= 0 and no accept occurs that cycle, even if in_valid=1.
  - in_ready is still computed as above, but the offered instruction is dropped and fetch must re-present it.
  - Data fields may keep stale values.
- Priority per edge: rst > flush > accept > drain.
- Reset mid-operation: an in-flight bundle is lost and the write-back pending that edge is lost.

Test Plan:
- Reset, then WB=1 WB_add=5 datain=0x55; next cycle accept instruction with src1=5, src2=6 -> after 1 cycle out_valid=1, src1=0x55, src2=0, src1_reg=5, src2_reg=6.
- Same-edge bypass: WB=1 WB_add=3 datain=0xABCD while accepting src1=3, src2=3 -> src1=src2=0xABCD; a later read of reg 3 also returns 0xABCD.
- Backpressure: out_ready=0 with a valid bundle -> in_ready=0, outputs frozen for 5 cycles despite in_valid toggling and WB to src1_reg; out_ready=1 -> next instruction accepted in the same cycle.
- ZERO_REG=1: write 0x1234 to reg 0, then read src1=0 -> src1=0. ZERO_REG=0 repeat -> src1=0x1234.
- Flush with in_valid=1 -> out_valid=0 next cycle, instruction not decoded; re-present it -> decoded normally.
- NREGS=8, DATA_W=16: WB_add=7 datain=0xFFFF, instruction src1 field=15 -> src1=0xFFFF, src1_reg=15.

Source files
------------

// File: rtl/decode_regfile_v2.sv
`default_nettype none
// ============================================================================
// Module   : decode_regfile_v2
// Purpose  : Decode stage of the core. Holds the architectural register file,
//            splits the 32-bit instruction into its fields, reads two source
//            operands (with same-edge write-back bypass) and registers the
//            result into a single-entry decode/execute pipeline register with
//            a valid/ready handshake and flush.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            in_valid/in_ready - fetch-side handshake
//            instruction       - [31:25] opcode [24:20] dst [19:15] src1
//                                [14:10] src2 [9:0] offsetlo
//            flush             - drop pipeline register contents
//            WB/WB_add/datain  - register-file write-back port
//            out_valid/out_ready - execute-side handshake
//            opcode, dst, src1_reg, src2_reg, offsetlo - registered fields
//            src1, src2        - registered operands
// Revision : 2.0 - handshake, flush, bypass, zero register, src2 reporting
// ============================================================================
module decode_regfile_v2 #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic              flush,
  input  logic              WB,
  input  logic [AW-1:0]     WB_add,
  input  logic [DATA_W-1:0] datain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        opcode,
  output logic [4:0]        dst,
  output logic [4:0]        src1_reg,
  output logic [4:0]        src2_reg,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  output logic [9:0]        offsetlo
);

  logic [DATA_W-1:0] rf_q [NREGS];

  logic              out_valid_q, out_valid_d;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] src1_q, src2_q;

  logic [AW-1:0]     rd1_idx, rd2_idx;
  logic [DATA_W-1:0] rd1_data, rd2_data;
  logic              wb_en;
  logic              accept;

  // Only the low AW bits of each source field address the file; the full
  // 5-bit field is still reported through src*_reg.
  assign rd1_idx = instruction[15 +: AW];
  assign rd2_idx = instruction[10 +: AW];

  // Writes to the hard-wired zero register are dropped.
  assign wb_en = WB && !((ZERO_REG != 0) && (WB_add == '0));

  // Read ports: zero register first, then same-edge write-back bypass, then
  // the stored value.
  always_comb begin
    if ((ZERO_REG != 0) && (rd1_idx == '0)) begin
      rd1_data = '0;
    end else if (WB && (WB_add == rd1_idx)) begin
      rd1_data = datain;
    end else begin
      rd1_data = rf_q[rd1_idx];
    end
  end

  always_comb begin
    if ((ZERO_REG != 0) && (rd2_idx == '0)) begin
      rd2_data = '0;
    end else if (WB && (WB_add == rd2_idx)) begin
      rd2_data = datain;
    end else begin
      rd2_data = rf_q[rd2_idx];
    end
  end

  // Skid-less single-entry register: accept whenever it is empty or being
  // drained this cycle. Flush suppresses the accept but not in_ready.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
    end else begin
      if (wb_en) begin
        rf_q[WB_add] <= datain;
      end
      out_valid_q <= out_valid_d;
      // Operands are captured only on accept, so a held bundle keeps its
      // operands even if the source registers are written meanwhile.
      if (accept) begin
        instr_q <= instruction;
        src1_q  <= rd1_data;
        src2_q  <= rd2_data;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = instr_q[31:25];
  assign dst       = instr_q[24:20];
  assign src1_reg  = instr_q[19:15];
  assign src2_reg  = instr_q[14:10];
  assign offsetlo  = instr_q[9:0];
  assign src1      = src1_q;
  assign src2      = src2_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_regfile_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_regfile_v2
// Purpose  : Self-checking bench for decode_regfile_v2. Three instances share
//            one stimulus stream: A (defaults), Z (ZERO_REG=1) and
//            S (NREGS=8, DATA_W=16). Directed table vectors, hand-written
//            multi-cycle sequences, then randomized traffic against a
//            behavioural model.
// Revision : 1.0
// ============================================================================
module tb_decode_regfile_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruction;
  logic        flush;
  logic        WB;
  logic [4:0]  WB_add;
  logic [31:0] datain;
  logic        out_ready;

  logic        a_rdy, a_ov, z_rdy, z_ov, s_rdy, s_ov;
  logic [6:0]  a_op, z_op, s_op;
  logic [4:0]  a_dst, a_r1, a_r2, z_dst, z_r1, z_r2, s_dst, s_r1, s_r2;
  logic [9:0]  a_off, z_off, s_off;
  logic [31:0] a_s1, a_s2, z_s1, z_s2;
  logic [15:0] s_s1, s_s2;
  logic [31:0] a_f, z_f, s_f;

  assign a_f = {a_op, a_dst, a_r1, a_r2, a_off};
  assign z_f = {z_op, z_dst, z_r1, z_r2, z_off};
  assign s_f = {s_op, s_dst, s_r1, s_r2, s_off};

  always #5 clk = ~clk;

  decode_regfile_v2 #(.DATA_W(32), .NREGS(32), .ZERO_REG(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy),
    .instruction(instruction), .flush(flush), .WB(WB), .WB_add(WB_add),
    .datain(datain), .out_valid(a_ov), .out_ready(out_ready),
    .opcode(a_op), .dst(a_dst), .src1_reg(a_r1), .src2_reg(a_r2),
    .src1(a_s1), .src2(a_s2), .offsetlo(a_off));

  decode_regfile_v2 #(.DATA_W(32), .NREGS(32), .ZERO_REG(1)) u_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_rdy),
    .instruction(instruction), .flush(flush), .WB(WB), .WB_add(WB_add),
    .datain(datain), .out_valid(z_ov), .out_ready(out_ready),
    .opcode(z_op), .dst(z_dst), .src1_reg(z_r1), .src2_reg(z_r2),
    .src1(z_s1), .src2(z_s2), .offsetlo(z_off));

  decode_regfile_v2 #(.DATA_W(16), .NREGS(8), .ZERO_REG(0)) u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_rdy),
    .instruction(instruction), .flush(flush), .WB(WB), .WB_add(WB_add[2:0]),
    .datain(datain[15:0]), .out_valid(s_ov), .out_ready(out_ready),
    .opcode(s_op), .dst(s_dst), .src1_reg(s_r1), .src2_reg(s_r2),
    .src1(s_s1), .src2(s_s2), .offsetlo(s_off));

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] d, input logic [4:0] r1,
                                     input logic [4:0] r2);
    return {7'h11, d, r1, r2, 10'h3A5};
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ins, input logic fl,
                       input logic wb, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ordy);
    in_valid    = iv;
    instruction = ins;
    flush       = fl;
    WB          = wb;
    WB_add      = wa;
    datain      = wd;
    out_ready   = ordy;
  endtask

  // ---------------- behavioural reference model ----------------
  // Per configuration: address mask, data mask, zero-register flag.
  int unsigned amask [3] = '{31, 31, 7};
  logic [31:0] dmask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
  bit          zr    [3] = '{1'b0, 1'b1, 1'b0};

  logic [31:0] m_rf [3][32];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_s1 [3];
  logic [31:0] m_s2 [3];

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 32; r++) m_rf[c][r] = '0;
      m_s1[c] = '0;
      m_s2[c] = '0;
    end
    m_valid = 1'b0;
    m_instr = '0;
  endtask

  function automatic logic [31:0] m_read(input int c, input logic [4:0] field);
    int unsigned idx = int'(field) & amask[c];
    if (zr[c] && idx == 0) return '0;
    if (WB && ((int'(WB_add) & amask[c]) == idx)) return datain & dmask[c];
    return m_rf[c][idx];
  endfunction

  task automatic model_edge();
    bit acc;
    if (rst) begin
      model_reset();
      return;
    end
    acc = in_valid && (!m_valid || out_ready) && !flush;
    if (acc) begin
      m_instr = instruction;
      for (int c = 0; c < 3; c++) begin
        m_s1[c] = m_read(c, instruction[19:15]);
        m_s2[c] = m_read(c, instruction[14:10]);
      end
    end
    if (flush)                      m_valid = 1'b0;
    else if (acc)                   m_valid = 1'b1;
    else if (m_valid && out_ready)  m_valid = 1'b0;
    if (WB) begin
      for (int c = 0; c < 3; c++) begin
        int unsigned a = int'(WB_add) & amask[c];
        if (!(zr[c] && a == 0)) m_rf[c][a] = datain & dmask[c];
      end
    end
  endtask

  task automatic chk_inst(input string tag, input logic ov, input logic [31:0] f,
                          input logic [31:0] s1, input logic [31:0] s2, input int c);
    chk({tag, "_valid"}, 64'(ov), 64'(m_valid));
    if (m_valid) begin
      chk({tag, "_fields"}, 64'(f), 64'(m_instr));
      chk({tag, "_src1"}, 64'(s1), 64'(m_s1[c]));
      chk({tag, "_src2"}, 64'(s2), 64'(m_s2[c]));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       nm;
    logic        iv;
    logic [31:0] ins;
    logic        fl, wb;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ordy, erdy, ev;
    logic [31:0] ei, a1, a2, z1, s1;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{"wb5",       1'b0, 32'h0,       1'b0, 1'b1, 5'd5, 32'h55,   1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vt[1] = '{"read5_6",   1'b1, mk(1,5,6),   1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b1, mk(1,5,6), 32'h55, 32'h0, 32'h55, 32'h55};
    vt[2] = '{"bypass3",   1'b1, mk(2,3,3),   1'b0, 1'b1, 5'd3, 32'hABCD, 1'b1, 1'b1, 1'b1, mk(2,3,3), 32'hABCD, 32'hABCD, 32'hABCD, 32'hABCD};
    vt[3] = '{"reread3",   1'b1, mk(0,3,5),   1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b1, mk(0,3,5), 32'hABCD, 32'h55, 32'hABCD, 32'hABCD};
    vt[4] = '{"wb0",       1'b0, 32'h0,       1'b0, 1'b1, 5'd0, 32'h1234, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vt[5] = '{"read0",     1'b1, mk(0,0,0),   1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b1, mk(0,0,0), 32'h1234, 32'h1234, 32'h0, 32'h1234};
    vt[6] = '{"wb7",       1'b0, 32'h0,       1'b0, 1'b1, 5'd7, 32'hFFFF, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vt[7] = '{"read15",    1'b1, mk(0,15,7),  1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b1, mk(0,15,7), 32'h0, 32'hFFFF, 32'h0, 32'hFFFF};
    vt[8] = '{"flush",     1'b1, mk(4,5,5),   1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vt[9] = '{"represent", 1'b1, mk(4,5,5),   1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b1, mk(4,5,5), 32'h55, 32'h55, 32'h55, 32'h55};
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_valid", 64'({a_ov, z_ov, s_ov}), 64'd0);
    chk("rst_fields", 64'({a_f, s_f}), 64'd0);
    chk("rst_ops", 64'({a_s1, a_s2}), 64'd0);
    chk("rst_ops_s", 64'({s_s1, s_s2, z_s1}), 64'd0);
    chk("rst_ready", 64'({a_rdy, z_rdy, s_rdy}), 64'b111);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vt[i].iv, vt[i].ins, vt[i].fl, vt[i].wb, vt[i].wa, vt[i].wd, vt[i].ordy);
      #1;
      chk({vt[i].nm, "_ready"}, 64'(a_rdy), 64'(vt[i].erdy));
      @(posedge clk);
      #1;
      chk({vt[i].nm, "_valid"}, 64'({a_ov, z_ov, s_ov}), {3{vt[i].ev}});
      if (vt[i].ev) begin
        chk({vt[i].nm, "_fields_a"}, 64'(a_f), 64'(vt[i].ei));
        chk({vt[i].nm, "_fields_s"}, 64'(s_f), 64'(vt[i].ei));
        chk({vt[i].nm, "_a_src1"}, 64'(a_s1), 64'(vt[i].a1));
        chk({vt[i].nm, "_a_src2"}, 64'(a_s2), 64'(vt[i].a2));
        chk({vt[i].nm, "_z_src1"}, 64'(z_s1), 64'(vt[i].z1));
        chk({vt[i].nm, "_s_src1"}, 64'(s_s1), 64'(vt[i].s1));
      end
    end

    // Backpressure: held bundle mk(4,5,5) must stay frozen, including
    // operands, while reg 5 is rewritten.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(i[0], mk(7,1,2), 1'b0, 1'b1, 5'd5, 32'h900 + i, 1'b0);
      #1;
      chk("bp_ready", 64'({a_rdy, z_rdy, s_rdy}), 64'b000);
      @(posedge clk);
      #1;
      chk("bp_valid", 64'({a_ov, z_ov, s_ov}), 64'b111);
      chk("bp_fields", 64'(a_f), 64'(mk(4,5,5)));
      chk("bp_src1", 64'({a_s1, s_s1}), {32'h55, 16'h55});
      chk("bp_src2", 64'(z_s2), 64'h55);
    end
    @(negedge clk);
    drive(1'b1, mk(6,5,1), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    #1;
    chk("bp_release_ready", 64'(a_rdy), 64'd1);
    @(posedge clk);
    #1;
    chk("bp_release_valid", 64'(a_ov), 64'd1);
    chk("bp_release_fields", 64'(a_f), 64'(mk(6,5,1)));
    chk("bp_release_src1", 64'({a_s1, s_s1}), {32'h904, 16'h904});

    // Reset mid-operation: bundle and concurrent write-back are lost.
    @(negedge clk);
    drive(1'b1, mk(0,9,9), 1'b0, 1'b1, 5'd9, 32'h77, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'({a_ov, z_ov, s_ov}), 64'd0);
    chk("midrst_fields", 64'(a_f), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, mk(0,9,5), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    chk("midrst_read_valid", 64'(a_ov), 64'd1);
    chk("midrst_read_ops", 64'({a_s1, a_s2}), 64'd0);

    // Randomized traffic against the model
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    model_edge();
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] r1, r2;
      @(negedge clk);
      r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      drive($urandom_range(0, 9) < 7,
            {7'($urandom), 5'($urandom), r1, r2, 10'($urandom)},
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
            $urandom,
            $urandom_range(0, 9) < 7);
      rst = (n == 0) || ($urandom_range(0, 49) == 0);
      if (rst) model_reset();
      #1;
      chk("rnd_ready", 64'({a_rdy, z_rdy, s_rdy}), {3{!m_valid || out_ready}});
      @(posedge clk);
      model_edge();
      #1;
      chk_inst("rnd_a", a_ov, a_f, a_s1, a_s2, 0);
      chk_inst("rnd_z", z_ov, z_f, z_s1, z_s2, 1);
      chk_inst("rnd_s", s_ov, s_f, {16'h0, s_s1}, {16'h0, s_s2}, 2);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
